br_port_arbiter: RTL and testbench
==================================

Name: br_port_arbiter

Overview:
Arbitrates N requesters (cache/RAMIO, flash loader, future DMA) onto the single burst-RAM command interface of the PSRAM controller (br_cmd/br_cmd_en/br_addr/br_wr_data/br_data_mask/br_rd_data/br_rd_data_valid). It serialises whole bursts, enforces command spacing and read timeouts, and routes read beats back to the granted port. It sits between the RAMIO-class clients and the PSRAM controller, and is generalised in port count, widths, burst length and arbitration mode.

Parameters:
NUM_PORTS, 2, number of requesters (1..8)
ADDR_WIDTH, 21, burst-RAM address width
DATA_WIDTH, 64, beat width; mask width = DATA_WIDTH/8
BURST_BEATS, 4, beats per burst (2..16)
ARB_MODE, 0, 0 = round-robin; 1 = fixed priority, port 0 highest
CMD_GAP_CYCLES, 4, idle cycles after each burst before the next command (>=1)
READ_TIMEOUT, 64, max cycles from read command to the first and between read beats

Ports:
clk  in  1  controller user clock (clk_out domain)
rst  in  1  asynchronous reset, active-high
br_init_calib  in  1  controller ready; no command is issued while 0
req  in  NUM_PORTS  per-port request, held until done
req_cmd  in  NUM_PORTS  0 read, 1 write
req_addr  in  NUM_PORTS*ADDR_WIDTH  burst address, stable while req
req_wr_data  in  NUM_PORTS*DATA_WIDTH  current write beat
req_data_mask  in  NUM_PORTS*DATA_WIDTH/8  current beat mask
wr_ack  out  NUM_PORTS  beat on req_wr_data consumed; port advances to next beat
rd_data  out  DATA_WIDTH  br_rd_data passthrough
rd_valid  out  NUM_PORTS  read beat valid, granted port only
done  out  NUM_PORTS  one-cycle completion pulse
err  out  NUM_PORTS  qualifies done: read timed out
br_cmd, br_cmd_en  out  1,1  controller command
br_addr  out  ADDR_WIDTH  controller address
br_wr_data  out  DATA_WIDTH  controller write data
br_data_mask  out  DATA_WIDTH/8  controller mask
br_rd_data  in  DATA_WIDTH;  br_rd_data_valid  in  1

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; beat and timer counters 0; RR pointer last = NUM_PORTS-1, so port 0 wins first.
- IDLE: if br_init_calib && |req, pick the winner (RR: first requesting port after last, wrapping modulo NUM_PORTS; fixed: lowest index). Register grant index, cmd and addr. Go to ISSUE. No outputs change in this cycle.
- ISSUE (1 cycle): br_cmd_en=1, br_cmd and br_addr from the latched values.
  - Write: br_wr_data/br_data_mask = granted port's beat 0 (combinational mux); wr_ack[g]=1; beat=1. Go to WBEATS (BURST_BEATS>1).
  - Read: timer=0. Go to RWAIT.
- WBEATS: one beat per cycle, no stalls. br_wr_data from port g; wr_ack[g]=1. After beat BURST_BEATS-1, go to GAP.
- RWAIT: rd_data = br_rd_data always. On each br_rd_data_valid: rd_valid[g]=1, timer reset. After the BURST_BEATS-th beat, go to GAP. If timer reaches READ_TIMEOUT: err[g]=1 with done, go to GAP.
- GAP: done[g] pulses on the first GAP cycle. Stay CMD_GAP_CYCLES cycles, then IDLE; RR last = g.
- br_rd_data_valid outside RWAIT: ignored, no rd_valid.
- Extra beats after a timeout are dropped.
- req deasserted mid-burst: burst still completes; a port must not drop req before done.
- br_init_calib falling mid-burst: the burst finishes; the next IDLE blocks.
- Minimum latency: request to cmd_en = 2 cycles. Write total = 1 + BURST_BEATS + CMD_GAP_CYCLES cycles.
- br_cmd_en is high exactly one cycle per burst; it is never high outside ISSUE.

Decomposition:
- Package br_pkg: state enum (IDLE, ISSUE, WBEATS, RWAIT, GAP); BR_CMD_READ=0 and BR_CMD_WRITE=1; ARB_ROUND_ROBIN=0 and ARB_FIXED=1.
- Sub-module br_rr_picker: combinational, parameterised NUM_PORTS/ARB_MODE, (req, last) -> (valid, index).
- Grant index width is max(1,$clog2(NUM_PORTS)).

Test Plan:
- Single write, port 0, addr 0x00100, beats 0x11..,0x22..,0x33..,0x44..: cmd_en on cycle 2 with cmd=1; four consecutive wr_ack[0]; br_wr_data matches in order; done[0] 1 cycle later; next cmd_en no earlier than CMD_GAP_CYCLES after.
- Read, port 1, addr 0x1FFE0; controller returns 4 beats after 10 cycles with 1 idle gap: rd_valid[1] on exactly those 4 cycles; rd_valid[0] stays 0; done[1] with err=0.
- RR fairness, ports 0 and 1 requesting continuously for 6 bursts: grants 0,1,0,1,0,1. With ARB_MODE=1 (fixed priority): grants 0,0,0 while port 0 keeps requesting.
- Timeout, READ_TIMEOUT=64, read with no valid beats: done[g]=err[g]=1 exactly 64 cycles after cmd_en; a late stray br_rd_data_valid produces no rd_valid.
- Calibration gating: req with br_init_calib=0 for 100 cycles -> no cmd_en; calib rises -> cmd_en 2 cycles later.
- Reset asserted mid-WBEATS (beat 2): all outputs 0 immediately; after release, the pending req is re-served from beat 0 with port 0 priority.

Source files
------------

// File: rtl/br_pkg.sv
// Shared types and constants for the burst-RAM port arbiter.
// Imported by the arbiter top and its request picker.
package br_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WBEATS = 3'd2,
        RWAIT  = 3'd3,
        GAP    = 3'd4
    } br_state_e;

    localparam logic BR_CMD_READ  = 1'b0;
    localparam logic BR_CMD_WRITE = 1'b1;

    localparam int ARB_ROUND_ROBIN = 0;
    localparam int ARB_FIXED       = 1;

    // Grant index width; a single-port build still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/br_rr_picker.sv
// Combinational winner selection: round-robin after 'last' or fixed
// priority with port 0 highest.
module br_rr_picker
    import br_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ARB_MODE  = ARB_ROUND_ROBIN,
    localparam int IW       = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IW-1:0]        last,
    output logic                 valid,
    output logic [IW-1:0]        index
);

    logic [IW-1:0] cand;

    // NOTE: every signal gets a default before the loops so no path leaves it unassigned (no latch).
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        if (ARB_MODE == ARB_FIXED) begin
            // Scan downward so the lowest requesting index is written last.
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                cand = IW'(i);
                if (req[cand]) begin
                    valid = 1'b1;
                    index = cand;
                end
            end
        end else begin
            // Distance 1 from 'last' is visited last and therefore wins.
            for (int i = NUM_PORTS; i >= 1; i--) begin
                cand = IW'((int'(last) + i) % NUM_PORTS);
                if (req[cand]) begin
                    valid = 1'b1;
                    index = cand;
                end
            end
        end
    end

endmodule

// File: rtl/br_port_arbiter.sv
// Serialises whole bursts from NUM_PORTS requesters onto the PSRAM
// controller burst-RAM command interface and routes read beats back.
module br_port_arbiter
    import br_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 21,
    parameter int DATA_WIDTH     = 64,
    parameter int BURST_BEATS    = 4,
    parameter int ARB_MODE       = ARB_ROUND_ROBIN,
    parameter int CMD_GAP_CYCLES = 4,
    parameter int READ_TIMEOUT   = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            br_init_calib,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS-1:0]            req_cmd,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wr_data,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_data_mask,
    output logic [NUM_PORTS-1:0]            wr_ack,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [NUM_PORTS-1:0]            rd_valid,
    output logic [NUM_PORTS-1:0]            done,
    output logic [NUM_PORTS-1:0]            err,
    output logic                            br_cmd,
    output logic                            br_cmd_en,
    output logic [ADDR_WIDTH-1:0]           br_addr,
    output logic [DATA_WIDTH-1:0]           br_wr_data,
    output logic [DATA_WIDTH/8-1:0]         br_data_mask,
    input  logic [DATA_WIDTH-1:0]           br_rd_data,
    input  logic                            br_rd_data_valid
);

    localparam int IW = idx_width(NUM_PORTS);
    localparam int MW = DATA_WIDTH / 8;
    localparam int BW = $clog2(BURST_BEATS);
    localparam int TW = $clog2(READ_TIMEOUT + 1);
    localparam int GW = $clog2(CMD_GAP_CYCLES + 1);

    br_state_e              state_q, state_d;
    logic [IW-1:0]          grant_q, grant_d;
    logic [IW-1:0]          last_q, last_d;
    logic                   cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic                   terr_q, terr_d;

    logic                   pick_valid;
    logic [IW-1:0]          pick_idx;

    br_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .ARB_MODE  (ARB_MODE)
    ) u_picker (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        timer_d = timer_q;
        gap_d   = gap_q;
        terr_d  = terr_q;
        unique case (state_q)
            IDLE: begin
                if (br_init_calib && pick_valid) begin
                    grant_d = pick_idx;
                    cmd_d   = req_cmd[pick_idx];
                    addr_d  = req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    terr_d  = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_q == BR_CMD_WRITE) begin
                    beat_d  = BW'(1);
                    state_d = (BURST_BEATS > 1) ? WBEATS : GAP;
                end else begin
                    // Timer holds cycles elapsed since the command or the last beat.
                    beat_d  = '0;
                    timer_d = TW'(1);
                    state_d = RWAIT;
                end
            end
            WBEATS: begin
                if (beat_q == BW'(BURST_BEATS - 1)) state_d = GAP;
                else                                beat_d  = beat_q + BW'(1);
            end
            RWAIT: begin
                if (br_rd_data_valid) begin
                    timer_d = TW'(1);
                    if (beat_q == BW'(BURST_BEATS - 1)) state_d = GAP;
                    else                                beat_d  = beat_q + BW'(1);
                end else if (timer_q == TW'(READ_TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = GAP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            GAP: begin
                if (gap_q == GW'(CMD_GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    beat_d  = '0;
                    last_d  = grant_q;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only, so an async reset clears them at once.
    always_comb begin
        wr_ack       = '0;
        rd_valid     = '0;
        done         = '0;
        err          = '0;
        rd_data      = '0;
        br_cmd       = 1'b0;
        br_cmd_en    = 1'b0;
        br_addr      = '0;
        br_wr_data   = '0;
        br_data_mask = '0;
        unique case (state_q)
            ISSUE: begin
                br_cmd_en = 1'b1;
                br_cmd    = cmd_q;
                br_addr   = addr_q;
                if (cmd_q == BR_CMD_WRITE) begin
                    br_wr_data      = req_wr_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
                    br_data_mask    = req_data_mask[grant_q*MW +: MW];
                    wr_ack[grant_q] = 1'b1;
                end
            end
            WBEATS: begin
                br_wr_data      = req_wr_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
                br_data_mask    = req_data_mask[grant_q*MW +: MW];
                wr_ack[grant_q] = 1'b1;
            end
            RWAIT: begin
                rd_data           = br_rd_data;
                rd_valid[grant_q] = br_rd_data_valid;
            end
            GAP: begin
                if (gap_q == '0) begin
                    done[grant_q] = 1'b1;
                    err[grant_q]  = terr_q;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_PORTS - 1);
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            beat_q  <= '0;
            timer_q <= '0;
            gap_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
            terr_q  <= terr_d;
        end
    end

endmodule

// File: tb/tb_br_port_arbiter.sv
// Scoreboard bench for br_port_arbiter: directed bursts push expectations,
// negedge monitors pop and compare whenever the DUT presents an output.
module tb_br_port_arbiter;
    import br_pkg::*;

    localparam int NP  = 2;
    localparam int AW  = 21;
    localparam int DW  = 64;
    localparam int MW  = 8;
    localparam int BB  = 4;
    localparam int GAPC = 4;
    localparam int RTO = 64;

    typedef struct { logic cmd; logic [AW-1:0] addr; } cmd_t;
    typedef struct { int port; logic [DW-1:0] data; logic [MW-1:0] mask; } wb_t;
    typedef struct { int port; logic [DW-1:0] data; } rb_t;
    typedef struct { int port; logic err; } dn_t;

    cmd_t          exp_cmd[$];
    wb_t           exp_wb[$];
    rb_t           exp_rb[$];
    dn_t           exp_done[$];
    logic [AW-1:0] exp_fp[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic clk = 1'b0;
    logic rst;
    logic br_init_calib;
    logic [NP-1:0]    req, req_cmd;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wr_data;
    logic [NP*MW-1:0] req_data_mask;
    logic [NP-1:0]    wr_ack, rd_valid, done, err;
    logic [DW-1:0]    rd_data, br_wr_data, br_rd_data;
    logic             br_cmd, br_cmd_en, br_rd_data_valid;
    logic [AW-1:0]    br_addr;
    logic [MW-1:0]    br_data_mask;

    logic [NP-1:0]    fp_req, fp_req_cmd, fp_wr_ack, fp_rd_valid, fp_done, fp_err;
    logic [NP*AW-1:0] fp_req_addr;
    logic [NP*DW-1:0] fp_req_wr_data;
    logic [NP*MW-1:0] fp_req_data_mask;
    logic [DW-1:0]    fp_rd_data, fp_br_wr_data, fp_br_rd_data;
    logic             fp_calib, fp_br_cmd, fp_br_cmd_en, fp_br_rd_data_valid;
    logic [AW-1:0]    fp_br_addr;
    logic [MW-1:0]    fp_br_data_mask;

    logic [DW-1:0] wpat [NP] = '{64'h1111_1111_1111_1111, 64'h0102_0408_1020_4080};
    logic [DW-1:0] rdat [BB] = '{64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0002,
                                 64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0004};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    br_port_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_BEATS(BB),
        .ARB_MODE(ARB_ROUND_ROBIN), .CMD_GAP_CYCLES(GAPC), .READ_TIMEOUT(RTO)
    ) dut (
        .clk(clk), .rst(rst), .br_init_calib(br_init_calib),
        .req(req), .req_cmd(req_cmd), .req_addr(req_addr),
        .req_wr_data(req_wr_data), .req_data_mask(req_data_mask),
        .wr_ack(wr_ack), .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .err(err), .br_cmd(br_cmd), .br_cmd_en(br_cmd_en),
        .br_addr(br_addr), .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
        .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid)
    );

    br_port_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_BEATS(BB),
        .ARB_MODE(ARB_FIXED), .CMD_GAP_CYCLES(GAPC), .READ_TIMEOUT(RTO)
    ) dut_fp (
        .clk(clk), .rst(rst), .br_init_calib(fp_calib),
        .req(fp_req), .req_cmd(fp_req_cmd), .req_addr(fp_req_addr),
        .req_wr_data(fp_req_wr_data), .req_data_mask(fp_req_data_mask),
        .wr_ack(fp_wr_ack), .rd_data(fp_rd_data), .rd_valid(fp_rd_valid),
        .done(fp_done), .err(fp_err), .br_cmd(fp_br_cmd), .br_cmd_en(fp_br_cmd_en),
        .br_addr(fp_br_addr), .br_wr_data(fp_br_wr_data), .br_data_mask(fp_br_data_mask),
        .br_rd_data(fp_br_rd_data), .br_rd_data_valid(fp_br_rd_data_valid)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: unexpected value 0x%0h (cycle %0d)", name, act, cyc);
    endtask

    function automatic logic [DW-1:0] wbeat(input int p, input int k);
        return wpat[p] * 64'(k + 1);
    endfunction

    function automatic logic [MW-1:0] wmask(input int p, input int k);
        return {4'(p + 1), 4'(k + 1)};
    endfunction

    task automatic push_write(input int p, input logic [AW-1:0] a);
        exp_cmd.push_back('{BR_CMD_WRITE, a});
        for (int k = 0; k < BB; k++) exp_wb.push_back('{p, wbeat(p, k), wmask(p, k)});
        exp_done.push_back('{p, 1'b0});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (br_cmd_en) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) fail_now("cmd_en_timeout", 64'(budget));
    endtask

    task automatic wait_done(input int p, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done[p]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) fail_now("done_timeout", 64'(p));
    endtask

    // Write client model: present beat idx, advance on wr_ack, rewind on done or reset.
    initial begin : client
        int idx [NP];
        logic [NP-1:0] ack, dn;
        logic r;
        idx = '{0, 0};
        forever begin
            for (int p = 0; p < NP; p++) begin
                req_wr_data[p*DW +: DW]   = wbeat(p, idx[p]);
                req_data_mask[p*MW +: MW] = wmask(p, idx[p]);
            end
            @(negedge clk);
            ack = wr_ack;
            dn  = done;
            r   = rst;
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (r || dn[p]) idx[p] = 0;
                else if (ack[p]) idx[p] = idx[p] + 1;
            end
        end
    end

    // Scoreboard monitors.
    always @(negedge clk) begin : monitor
        cmd_t c;
        wb_t  w;
        rb_t  r;
        dn_t  d;
        if (br_cmd_en) begin
            if (exp_cmd.size() == 0) fail_now("cmd_unexpected", 64'(br_addr));
            else begin
                c = exp_cmd.pop_front();
                check("cmd_kind", 64'(br_cmd), 64'(c.cmd));
                check("cmd_addr", 64'(br_addr), 64'(c.addr));
            end
        end
        if (|wr_ack) begin
            if (exp_wb.size() == 0) fail_now("wr_ack_unexpected", 64'(wr_ack));
            else begin
                w = exp_wb.pop_front();
                check("wr_ack_port", 64'(wr_ack), 64'(2'b01 << w.port));
                check("wr_data", br_wr_data, w.data);
                check("wr_mask", 64'(br_data_mask), 64'(w.mask));
            end
        end
        if (|rd_valid) begin
            if (exp_rb.size() == 0) fail_now("rd_valid_unexpected", 64'(rd_valid));
            else begin
                r = exp_rb.pop_front();
                check("rd_valid_port", 64'(rd_valid), 64'(2'b01 << r.port));
                check("rd_data", rd_data, r.data);
            end
        end
        if (|done) begin
            if (exp_done.size() == 0) fail_now("done_unexpected", 64'(done));
            else begin
                d = exp_done.pop_front();
                check("done_port", 64'(done), 64'(2'b01 << d.port));
                check("done_err", 64'(err), d.err ? 64'(2'b01 << d.port) : 64'd0);
            end
        end else if (|err) begin
            fail_now("err_without_done", 64'(err));
        end
        if (fp_br_cmd_en) begin
            if (exp_fp.size() == 0) fail_now("fp_cmd_unexpected", 64'(fp_br_addr));
            else check("fp_grant_addr", 64'(fp_br_addr), 64'(exp_fp.pop_front()));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int t0, c, d, c2, nd, nc;
        int n;
        rst = 1'b1;
        br_init_calib = 1'b1;
        req = '0;
        req_cmd = '0;
        req_addr = '0;
        br_rd_data = 64'hBAD0_BAD0_BAD0_BAD0;
        br_rd_data_valid = 1'b0;
        fp_calib = 1'b1;
        fp_req = '0;
        fp_req_cmd = 2'b11;
        fp_req_addr = {21'h00B00, 21'h00A00};
        fp_req_wr_data = '0;
        fp_req_data_mask = '0;
        fp_br_rd_data = '0;
        fp_br_rd_data_valid = 1'b0;

        // Reset state: every output quiet even with junk on br_rd_data.
        #3;
        check("reset_ctl", 64'({wr_ack, rd_valid, done, err, br_cmd_en, br_cmd}), 64'd0);
        check("reset_data", br_wr_data | rd_data | 64'(br_addr) | 64'(br_data_mask), 64'd0);
        step(); step();
        rst = 1'b0;
        step();

        // Single write, port 0: cmd_en in the second cycle of the request.
        req_cmd[0] = BR_CMD_WRITE;
        req_addr[0*AW +: AW] = 21'h00100;
        push_write(0, 21'h00100);
        req[0] = 1'b1;
        t0 = cyc;
        wait_cmd(20, c);
        check("t1_cmd_latency", 64'(c - t0), 64'd1);
        check("t1_ack_beat0", 64'(wr_ack), 64'b01);
        for (int k = 1; k < BB; k++) begin
            @(negedge clk);
            check("t1_ack_consecutive", 64'(wr_ack), 64'b01);
        end
        @(negedge clk);
        check("t1_done_after_last_beat", 64'(done), 64'b01);
        d = cyc;
        check("t1_done_cycle", 64'(d - c), 64'(BB));

        // Read, port 1, raised immediately: next command waits out the gap.
        step();
        req[0] = 1'b0;
        req_cmd[1] = BR_CMD_READ;
        req_addr[1*AW +: AW] = 21'h1FFE0;
        exp_cmd.push_back('{BR_CMD_READ, 21'h1FFE0});
        for (int k = 0; k < BB; k++) exp_rb.push_back('{1, rdat[k]});
        exp_done.push_back('{1, 1'b0});
        req[1] = 1'b1;
        wait_cmd(40, c2);
        check("t2_cmd_spacing", 64'(c2 - d), 64'(GAPC + 1));
        n = 0;
        for (int off = 1; off <= 14; off++) begin
            step();
            if (off == 10 || off == 11 || off == 13 || off == 14) begin
                br_rd_data_valid = 1'b1;
                br_rd_data = rdat[n];
                n++;
            end else begin
                br_rd_data_valid = 1'b0;
                br_rd_data = 64'hBAD0_BAD0_BAD0_BAD0;
            end
        end
        step();
        br_rd_data_valid = 1'b0;
        @(negedge clk);
        check("t2_done", 64'(done), 64'b10);
        check("t2_err", 64'(err), 64'd0);
        check("t2_done_cycle", 64'(cyc - c2), 64'd15);
        step();
        req[1] = 1'b0;

        // Round-robin: both ports write continuously for six bursts.
        req_cmd = 2'b11;
        req_addr = {21'h00300, 21'h00200};
        for (int i = 0; i < 3; i++) begin
            push_write(0, 21'h00200);
            push_write(1, 21'h00300);
        end
        req = 2'b11;
        nd = 0;
        for (int i = 0; i < 300 && nd < 6; i++) begin
            @(negedge clk);
            if (|done) nd++;
        end
        check("t3_bursts", 64'(nd), 64'd6);
        step();
        req = 2'b00;

        // Fixed priority instance: port 0 wins while it keeps requesting.
        for (int i = 0; i < 3; i++) exp_fp.push_back(21'h00A00);
        exp_fp.push_back(21'h00B00);
        fp_req = 2'b11;
        nd = 0;
        for (int i = 0; i < 200 && nd < 3; i++) begin
            @(negedge clk);
            if (fp_done[0]) nd++;
        end
        check("t4_fp_port0_bursts", 64'(nd), 64'd3);
        step();
        fp_req[0] = 1'b0;
        nd = 0;
        for (int i = 0; i < 100 && nd < 1; i++) begin
            @(negedge clk);
            if (fp_done[1]) nd++;
        end
        check("t4_fp_port1_served", 64'(nd), 64'd1);
        step();
        fp_req = 2'b00;

        // Read timeout on port 0, then a stray beat that must be dropped.
        req_cmd[0] = BR_CMD_READ;
        req_addr[0*AW +: AW] = 21'h00400;
        exp_cmd.push_back('{BR_CMD_READ, 21'h00400});
        exp_done.push_back('{0, 1'b1});
        req[0] = 1'b1;
        wait_cmd(20, c);
        wait_done(0, 100, d);
        check("t5_timeout_cycle", 64'(d - c), 64'(RTO));
        check("t5_err", 64'(err), 64'b01);
        step();
        req[0] = 1'b0;
        br_rd_data_valid = 1'b1;
        br_rd_data = 64'h5757_5757_5757_5757;
        @(negedge clk);
        check("t5_stray_dropped", 64'(rd_valid), 64'd0);
        step();
        br_rd_data_valid = 1'b0;

        // Calibration gating.
        br_init_calib = 1'b0;
        req_cmd[0] = BR_CMD_WRITE;
        req_addr[0*AW +: AW] = 21'h00500;
        req[0] = 1'b1;
        nc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (br_cmd_en) nc++;
        end
        check("t6_no_cmd_uncalibrated", 64'(nc), 64'd0);
        step();
        push_write(0, 21'h00500);
        br_init_calib = 1'b1;
        t0 = cyc;
        wait_cmd(20, c);
        check("t6_calib_latency", 64'(c - t0), 64'd1);
        wait_done(0, 40, d);
        step();
        req[0] = 1'b0;
        for (int i = 0; i < GAPC + 1; i++) step();

        // Reset mid-burst: port 1 wins, reset hits during beat 2.
        req_cmd = 2'b11;
        req_addr = {21'h00700, 21'h00600};
        exp_cmd.push_back('{BR_CMD_WRITE, 21'h00700});
        exp_wb.push_back('{1, wbeat(1, 0), wmask(1, 0)});
        exp_wb.push_back('{1, wbeat(1, 1), wmask(1, 1)});
        req = 2'b11;
        wait_cmd(20, c);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t7_rst_ctl", 64'({wr_ack, rd_valid, done, err, br_cmd_en, br_cmd}), 64'd0);
        check("t7_rst_data", br_wr_data | rd_data | 64'(br_addr) | 64'(br_data_mask), 64'd0);
        check("t7_beats_before_rst", 64'(exp_wb.size()), 64'd0);
        step(); step();
        push_write(0, 21'h00600);
        push_write(1, 21'h00700);
        rst = 1'b0;
        wait_done(0, 40, d);
        step();
        req[0] = 1'b0;
        wait_done(1, 40, d);
        step();
        req[1] = 1'b0;

        for (int i = 0; i < 20; i++) step();
        check("end_cmd_queue", 64'(exp_cmd.size()), 64'd0);
        check("end_wb_queue", 64'(exp_wb.size()), 64'd0);
        check("end_rb_queue", 64'(exp_rb.size()), 64'd0);
        check("end_done_queue", 64'(exp_done.size()), 64'd0);
        check("end_fp_queue", 64'(exp_fp.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
